// File: rtl/writeback_unit_if.sv
// Writeback bus bundle: ALU and load result streams in, register-file write port and retire count out.
interface writeback_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;

  modport master (
    output alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  alu_ready, ld_ready, rf_we, rf_rd, rf_wdata, retire_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output alu_ready, ld_ready, rf_we, rf_rd, rf_wdata, retire_cnt
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU results against formatted load data, one registered
// register-file write per cycle, with a starvation counter so the ALU always makes progress.
module writeback_unit #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_wdata;
  logic [31:0]   r_retire_cnt;

  logic          w_at_limit;
  logic          w_grant_alu;
  logic          w_grant_ld;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld_data;
  logic [4:0]    w_win_rd;
  logic [31:0]   w_win_data;

  assign w_at_limit  = (r_starve == LIMIT);
  assign w_grant_alu = bus.alu_valid && (!bus.ld_valid || w_at_limit);
  assign w_grant_ld  = bus.ld_valid && !w_grant_alu;

  // Readies depend only on the other side's valid so a source can see them before offering.
  assign bus.ld_ready  = !(bus.alu_valid && w_at_limit);
  assign bus.alu_ready = !bus.ld_valid || w_at_limit;

  always_comb begin
    w_byte = bus.ld_rdata[7:0];
    case (bus.ld_addr_lo)
      2'd0: w_byte = bus.ld_rdata[7:0];
      2'd1: w_byte = bus.ld_rdata[15:8];
      2'd2: w_byte = bus.ld_rdata[23:16];
      2'd3: w_byte = bus.ld_rdata[31:24];
      default: w_byte = bus.ld_rdata[7:0];
    endcase
    w_half = bus.ld_addr_lo[1] ? bus.ld_rdata[31:16] : bus.ld_rdata[15:0];
    case (bus.ld_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.ld_rdata;
    endcase
  end

  assign w_win_rd   = w_grant_alu ? bus.alu_rd : bus.ld_rd;
  assign w_win_data = w_grant_alu ? bus.alu_result : w_ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve     <= '0;
      r_rf_we      <= 1'b0;
      r_rf_rd      <= 5'd0;
      r_rf_wdata   <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (w_grant_alu || !bus.alu_valid) begin
        r_starve <= '0;
      end else if (bus.ld_valid && !w_at_limit) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_grant_alu || w_grant_ld) begin
        r_rf_we      <= (w_win_rd != 5'd0);
        r_rf_rd      <= w_win_rd;
        r_rf_wdata   <= w_win_data;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  assign bus.rf_we      = r_rf_we;
  assign bus.rf_rd      = r_rf_rd;
  assign bus.rf_wdata   = r_rf_wdata;
  assign bus.retire_cnt = r_retire_cnt;
endmodule
